// File: rtl/bcd_gate_gen_if.sv
// bcd_gate_gen_if: control and status bundle for the BCD gate-pulse generator
interface bcd_gate_gen_if;
  logic        start;
  logic        abort;
  logic [15:0] len_bcd;
  logic        gate;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rem_bcd;
  modport master (output start, abort, len_bcd, input gate, busy, done, err, rem_bcd);
  modport slave  (input start, abort, len_bcd, output gate, busy, done, err, rem_bcd);
endinterface

// File: rtl/bcd_gate_gen.sv
// bcd_gate_gen: emits one gate pulse exactly len_bcd clk cycles wide using a BCD down-counter
module bcd_gate_gen (
  input logic          clk,
  input logic          clr,
  bcd_gate_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        start_q, gate_q, busy_q, done_q, err_q, err_d, edge_w;
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = !b ? v[4*i+:4] : (v[4*i+:4] == 4'd0 ? 4'd9 : v[4*i+:4] - 4'd1);
      b = b & (v[4*i+:4] == 4'd0);
    end
    return r;
  endfunction
  function automatic logic bcd_bad(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) r = r | (v[4*i+:4] > 4'd9);
    return r;
  endfunction
  assign edge_w = bus.start & ~start_q;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (edge_w) begin
        err_d = bcd_bad(bus.len_bcd);
        if (!err_d) begin
          state_d = bus.len_bcd == 16'h0000 ? DONE : RUN;
          rem_d   = bus.len_bcd;
        end
      end
      RUN: begin
        // the 0001 edge decrements to 0000 naturally while moving to DONE
        state_d = bus.abort ? IDLE : (rem_q == 16'h0001 ? DONE : RUN);
        rem_d   = bus.abort ? 16'h0000 : bcd_dec(rem_q);
      end
      default: begin
        state_d = IDLE;
        rem_d   = 16'h0000;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rem_q   <= 16'h0000;
      start_q <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      start_q <= bus.start;
      gate_q  <= state_d == RUN;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      err_q   <= err_d;
    end
  end
  assign bus.gate    = gate_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rem_bcd = rem_q;
endmodule
